// File: rtl/ppu_ctrl_pkg.sv
// ppu_ctrl_pkg: shared decode definitions for the PPU pipeline.
//   - opcode / R-type funct constants
//   - ctrl_word_t: 22-bit packed control word (bit 21 = cond_uncond ... bit 0 = mem_en)
//   - per-instruction control-word constants
//   - stall FSM state type
package ppu_ctrl_pkg;

  typedef struct packed {
    logic       cond_uncond;  // 21
    logic       r31;          // 20
    logic       uncond_jump;  // 19
    logic       dest;         // 18
    logic [2:0] src_op;       // 17:15
    logic [3:0] alu_op;       // 14:11
    logic       load;         // 10
    logic       rf_en;        // 9
    logic       b_instr;      // 8
    logic       ta_instr;     // 7
    logic [1:0] mem_size;     // 6:5
    logic       mem_rw;       // 4
    logic       mem_se;       // 3
    logic       en_hi;        // 2
    logic       en_lo;        // 1
    logic       mem_en;       // 0
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BGEZ  = 6'h01;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_B     = 6'h04;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SD    = 6'h3F;

  // R-type functs (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Control words
  localparam ctrl_word_t CTRL_NONE  = 22'h000000;
  localparam ctrl_word_t CTRL_ADDIU = 22'h160600;
  localparam ctrl_word_t CTRL_LUI   = 22'h168600;
  localparam ctrl_word_t CTRL_SUBU  = 22'h040A00;
  localparam ctrl_word_t CTRL_ADDU  = 22'h040200;
  localparam ctrl_word_t CTRL_JR    = 22'h080080;
  localparam ctrl_word_t CTRL_JAL   = 22'h180280;
  localparam ctrl_word_t CTRL_LB    = 22'h16060B;
  localparam ctrl_word_t CTRL_LBU   = 22'h160603;
  localparam ctrl_word_t CTRL_LH    = 22'h16062B;
  localparam ctrl_word_t CTRL_LHU   = 22'h160623;
  localparam ctrl_word_t CTRL_LW    = 22'h160643;
  localparam ctrl_word_t CTRL_SB    = 22'h020013;
  localparam ctrl_word_t CTRL_SH    = 22'h020033;
  localparam ctrl_word_t CTRL_SW    = 22'h020053;
  localparam ctrl_word_t CTRL_SD    = 22'h020077;
  localparam ctrl_word_t CTRL_BGTZ  = 22'h201100;
  localparam ctrl_word_t CTRL_BGEZ  = 22'h201900;
  localparam ctrl_word_t CTRL_B     = 22'h000100;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stall_state_e;

endpackage

// File: rtl/ppu_control_decoder.sv
// ppu_control_decoder: purely combinational instruction decoder.
//   instr    in  32  instruction to decode
//   ctrl     out 22  control word (0 for NOP or unrecognised encodings)
//   illegal  out 1   opcode/funct not recognised (never set for the all-zero NOP)
//   reads_rt out 1   instruction sources rt, so rt takes part in hazard matching
module ppu_control_decoder
  import ppu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [21:0] ctrl,
  output logic        illegal,
  output logic        reads_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    ctrl     = CTRL_NONE;
    illegal  = 1'b0;
    reads_rt = 1'b0;
    if (instr != 32'h0) begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_SUBU: begin ctrl = CTRL_SUBU; reads_rt = 1'b1; end
            FN_ADDU: begin ctrl = CTRL_ADDU; reads_rt = 1'b1; end
            FN_JR:   begin ctrl = CTRL_JR;   reads_rt = 1'b1; end
            default: illegal = 1'b1;
          endcase
        end
        OP_ADDIU: ctrl = CTRL_ADDIU;
        OP_LUI:   ctrl = CTRL_LUI;
        OP_JAL:   ctrl = CTRL_JAL;
        OP_LB:    ctrl = CTRL_LB;
        OP_LBU:   ctrl = CTRL_LBU;
        OP_LH:    ctrl = CTRL_LH;
        OP_LHU:   ctrl = CTRL_LHU;
        OP_LW:    ctrl = CTRL_LW;
        OP_SB:    begin ctrl = CTRL_SB;   reads_rt = 1'b1; end
        OP_SH:    begin ctrl = CTRL_SH;   reads_rt = 1'b1; end
        OP_SW:    begin ctrl = CTRL_SW;   reads_rt = 1'b1; end
        OP_SD:    begin ctrl = CTRL_SD;   reads_rt = 1'b1; end
        OP_BGTZ:  begin ctrl = CTRL_BGTZ; reads_rt = 1'b1; end
        OP_B:     begin ctrl = CTRL_B;    reads_rt = 1'b1; end
        OP_BGEZ:  ctrl = CTRL_BGEZ;
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ppu_decode_stage.sv
// ppu_decode_stage: registered ID stage of the PPU pipeline.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   if_instr   in   32  IF/ID instruction
//   if_valid   in   IF/ID instruction is real
//   ex_flush   in   taken branch/jump in EX; kill the ID instruction
//   ex_load    in   instruction in EX is a load
//   ex_rd      in   5   destination register of the EX instruction
//   stall_out  out  combinational load-use stall request to IF
//   id_ctrl    out  22  registered control word
//   id_instr   out  32  registered instruction (0 for a bubble)
//   id_valid   out  registered valid (0 for a bubble)
//   id_illegal out  registered illegal-encoding flag
//   ill_count  out  ILL_CNT_W saturating count of latched illegal instructions
//   dbg_bubble out  stall FSM is in its BUBBLE state (debug only)
module ppu_decode_stage
  import ppu_ctrl_pkg::*;
#(
  parameter logic HAZARD_EN = 1'b1,
  parameter logic FLUSH_EN  = 1'b1,
  parameter int   ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          if_instr,
  input  logic                 if_valid,
  input  logic                 ex_flush,
  input  logic                 ex_load,
  input  logic [4:0]           ex_rd,
  output logic                 stall_out,
  output logic [21:0]          id_ctrl,
  output logic [31:0]          id_instr,
  output logic                 id_valid,
  output logic                 id_illegal,
  output logic [ILL_CNT_W-1:0] ill_count,
  output logic                 dbg_bubble
);

  localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  logic [21:0] dec_ctrl;
  logic        dec_illegal;
  logic        dec_reads_rt;

  ppu_control_decoder u_decoder (
    .instr    (if_instr),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .reads_rt (dec_reads_rt)
  );

  logic [4:0] rs;
  logic [4:0] rt;
  logic       match;
  logic       hazard;
  logic       flush;
  logic       bubble;

  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign match  = (rs == ex_rd) || (dec_reads_rt && (rt == ex_rd));
  assign hazard = HAZARD_EN & if_valid & ex_load & (ex_rd != 5'd0) & match;
  assign flush  = FLUSH_EN & ex_flush;
  assign bubble = flush | hazard | ~if_valid;

  // A flush already kills the ID instruction, so holding IF would only lose
  // the fetch redirect. Reset gates the request so every output reads 0.
  assign stall_out = hazard & ~flush & ~reset;

  // Stall FSM: one BUBBLE cycle per load-use; by the next edge the load has
  // moved to MEM, so the held instruction can latch.
  stall_state_e state_q;
  stall_state_e state_d;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (hazard && !flush) state_d = ST_BUBBLE;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  assign dbg_bubble = (state_q == ST_BUBBLE);

  // ID/EX register and illegal counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ctrl    <= '0;
      id_instr   <= '0;
      id_valid   <= 1'b0;
      id_illegal <= 1'b0;
      ill_count  <= '0;
    end else if (bubble) begin
      id_ctrl    <= '0;
      id_instr   <= '0;
      id_valid   <= 1'b0;
      id_illegal <= 1'b0;
    end else begin
      id_ctrl    <= dec_ctrl;
      id_instr   <= if_instr;
      id_valid   <= 1'b1;
      id_illegal <= dec_illegal;
      if (dec_illegal && (ill_count != '1)) ill_count <= ill_count + CNT_ONE;
    end
  end

endmodule

// File: doc/ppu_decode_stage.md
# ppu_decode_stage

Registered instruction-decode stage for the PPU pipeline. It decodes the IF/ID instruction into the 22-bit control word and latches that word, the instruction and a valid bit into the ID/EX register. It detects load-use hazards against the EX stage and inserts one-cycle bubbles. It also honours branch/jump flushes from EX and keeps a saturating count of illegal opcodes. It sits between the fetch stage and the execute stage.

## Interface
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 means stall_out is tied to 0.
- FLUSH_EN, 1, 1 lets ex_flush insert a bubble; 0 means ex_flush is ignored.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- if_instr  input  32  instruction currently held in IF/ID.
- if_valid  input  1  if_instr is a real instruction.
- ex_flush  input  1  the branch/jump resolved in EX is taken; kill the ID instruction.
- ex_load  input  1  the instruction now in EX is a load (ID/EX ctrl bit 10).
- ex_rd  input  5  destination register of the instruction in EX.
- stall_out  output  1  combinational; IF must hold its PC and IF/ID register this cycle.
- id_ctrl  output  22  registered control word; bit 21 down to bit 0 are cond/uncond, r31, uncond_jump, dest, src_op[2:0], alu_op[3:0], load, rf_en, b_instr, ta_instr, mem_size[1:0], mem_rw, mem_se, en_hi, en_lo, mem_en.
- id_instr  output  32  registered copy of the decoded instruction; 0 for a bubble.
- id_valid  output  1  registered; 0 for a bubble.
- id_illegal  output  1  registered; the latched instruction had an unrecognised opcode or funct.
- ill_count  output  ILL_CNT_W  saturating count of latched illegal instructions.

## Operation
- Decode is combinational from if_instr and produces a 22-bit word plus an illegal flag.
- Recognised opcodes: ADDIU, LBU, LB, LH, LHU, LW, SB, SH, SW, SD, BGTZ, BGEZ, B, JAL and LUI.
- Recognised R-type functs: SUBU, ADDU and JR.
- All-zero instruction (NOP): ctrl = 0 and illegal = 0.
- Any other encoding: ctrl = 0 and illegal = 1.
- Hazard: hazard = HAZARD_EN & if_valid & ex_load & (ex_rd != 0) & match.
- match = (rs == ex_rd), or (rt == ex_rd) when the instruction reads rt. The rt readers are R-type, stores, BGTZ/B compare forms and SB/SH/SW/SD.
- stall_out = hazard & ~(FLUSH_EN & ex_flush).
- ID/EX update priority, highest first:
  - reset: all outputs go to 0.
  - flush (FLUSH_EN & ex_flush): bubble.
  - hazard: bubble; IF/ID is held by the upstream stage.
  - !if_valid: bubble.
  - otherwise: latch {ctrl, if_instr, 1, illegal}.
- A bubble writes id_ctrl = 0, id_instr = 0, id_valid = 0 and id_illegal = 0.
- ill_count increments by 1 on each edge that latches a non-bubble with illegal = 1. It holds at 2^ILL_CNT_W − 1 once saturated.
- Stall FSM, two states:
  - RUN to BUBBLE on hazard.
  - BUBBLE to RUN on the next edge. The held load has moved to MEM by then, so the hazard clears unless a new EX load matches.
  - BUBBLE is also left on reset or flush.
  - The state is exported only through stall_out and a debug bit.

## Timing
- Decode-to-id_ctrl latency is 1 cycle.
- stall_out is valid in the same cycle as if_instr, ex_load and ex_rd, with no register in that path.
- Load-use gives exactly 1 bubble cycle, followed by the held instruction latching on the next edge.
- Flush and hazard in the same cycle: flush wins, stall_out = 0 and one bubble is inserted.
- Reset asserted mid-stall or mid-flush clears everything asynchronously. The first edge after deassertion latches the current if_instr normally.
- ex_rd = 0 never causes a stall.
- ill_count does not wrap.

## Structure
- Shared package ppu_ctrl_pkg holds:
  - opcode and funct constants;
  - a 22-bit packed control-word typedef with the field names above;
  - per-instruction control constants (e.g. CTRL_ADDIU = 22'h160600, CTRL_SUBU = 22'h040A00).
- One sub-module, ppu_control_decoder: purely combinational, maps instruction to {ctrl, illegal, reads_rt}.
- ppu_decode_stage holds the hazard logic, the FSM, the ID/EX register and the counter.

## Test plan
- Reset, then if_instr = 0x2508_0004 (ADDIU) with if_valid = 1 → after 1 edge, id_ctrl = 0x160600, id_valid = 1 and id_instr = 0x25080004.
- R-type SUBU with funct 0x23 → id_ctrl = 0x040A00. NOP (0x00000000) → id_ctrl = 0, id_valid = 1, id_illegal = 0.
- ex_load = 1, ex_rd = 8, then ADDU with rs = 8 → stall_out = 1 in the same cycle and a bubble at the next edge. Holding the instruction one more cycle with ex_load = 0 → it latches. The same case with ex_rd = 0 → no stall.
- Hazard and ex_flush in the same cycle → stall_out = 0 and a bubble. FLUSH_EN = 0 → ex_flush has no effect.
- Opcode 0x3E presented 300 times with ILL_CNT_W = 8 → ill_count = 255 (saturated) and id_illegal = 1 with id_ctrl = 0 on each latch.
- Reset asserted mid-stall (between edges) → all outputs are 0 immediately, and normal latching resumes on the first edge after release.
